// File: rtl/ahblite_interconnect_pkg.sv
// ahblite_interconnect_pkg
//   Shared definitions for the AHB-Lite interconnect slice: default memory
//   map, the data-phase "default slave" select code, default-slave FSM
//   state encodings, HTRANS encodings and the address-match helper.
package ahblite_interconnect_pkg;

  // Default memory map (4 KiB windows starting at 0x4000_0000)
  localparam logic [31:0] DEF_S0_BASE = 32'h4000_0000;
  localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_S1_BASE = 32'h4000_1000;
  localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_S2_BASE = 32'h4000_2000;
  localparam logic [31:0] DEF_S2_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_S3_BASE = 32'h4000_3000;
  localparam logic [31:0] DEF_S3_MASK = 32'hFFFF_F000;

  // Data-phase select code meaning "built-in default slave"
  localparam logic [2:0] DSEL_DEFAULT = 3'd4;

  // Default-slave FSM states
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave
//   Answers every access that decodes to no slave. Active transfers
//   (NONSEQ/SEQ) get the two-cycle AHB ERROR response; IDLE/BUSY get a
//   zero-wait OKAY.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   sel             address phase decodes to no slave
//   htrans          master HTRANS
//   hready          shared bus HREADY (address phase is taken only when 1)
//   hreadyout       default-slave HREADYOUT
//   hresp           default-slave HRESP
module ahblite_default_slave
  import ahblite_interconnect_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       hreadyout,
  output logic       hresp
);

  ds_state_e state, state_nxt;
  logic      err_req;

  // An unmapped active transfer whose address phase is being accepted
  assign err_req = hready && sel &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= DS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (err_req) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = err_req ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Outputs depend on state only; hready feeds back from the bus mux, so
  // keeping this decode separate from next-state avoids a combinational loop.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      DS_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ahblite_interconnect.sv
// ahblite_interconnect
//   Single-master AHB-Lite address decoder, response multiplexer and
//   default slave for the Cortex-M0 peripheral bus.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HADDR, HTRANS  master address phase
//   HSEL_S         per-slave select (bit i = slave i), address phase
//   HREADYOUT_S    per-slave HREADYOUT
//   HRESP_S        per-slave HRESP
//   HRDATA_S       per-slave read data, slave i at [32i+31:32i]
//   HREADY         shared ready to master and all slaves
//   HRESP, HRDATA  response and read data to master
module ahblite_interconnect
  import ahblite_interconnect_pkg::*;
#(
  parameter int          NSLV    = 4,
  parameter logic [31:0] S0_BASE = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK = DEF_S1_MASK,
  parameter logic [31:0] S2_BASE = DEF_S2_BASE,
  parameter logic [31:0] S2_MASK = DEF_S2_MASK,
  parameter logic [31:0] S3_BASE = DEF_S3_BASE,
  parameter logic [31:0] S3_MASK = DEF_S3_MASK
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic [NSLV-1:0]      HSEL_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  input  logic [32*NSLV-1:0]   HRDATA_S,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [31:0]          HRDATA
);

  logic [2:0] dsel, dsel_nxt;
  logic       def_sel;
  logic       def_hreadyout;
  logic       def_hresp;

  // Address decode: lowest index wins on overlapping windows, so at most
  // one select is ever asserted. HTRANS is deliberately not qualified here.
  always_comb begin
    HSEL_S   = '0;
    dsel_nxt = DSEL_DEFAULT;
    if (addr_match(HADDR, S0_BASE, S0_MASK)) begin
      HSEL_S[0] = 1'b1;
      dsel_nxt  = 3'd0;
    end else if (addr_match(HADDR, S1_BASE, S1_MASK)) begin
      HSEL_S[1] = 1'b1;
      dsel_nxt  = 3'd1;
    end else if (addr_match(HADDR, S2_BASE, S2_MASK)) begin
      HSEL_S[2] = 1'b1;
      dsel_nxt  = 3'd2;
    end else if (addr_match(HADDR, S3_BASE, S3_MASK)) begin
      HSEL_S[3] = 1'b1;
      dsel_nxt  = 3'd3;
    end
  end

  assign def_sel = (dsel_nxt == DSEL_DEFAULT);

  // Data-phase select: a new address phase is taken only when HREADY is high
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    dsel <= DSEL_DEFAULT;
    else if (HREADY) dsel <= dsel_nxt;
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (def_sel),
    .htrans    (HTRANS),
    .hready    (HREADY),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp)
  );

  // Response mux; codes 4..7 all route to the default slave, whose read
  // data is always zero.
  always_comb begin
    HREADY = def_hreadyout;
    HRESP  = def_hresp;
    HRDATA = '0;
    if (!dsel[2]) begin
      HREADY = HREADYOUT_S[dsel[1:0]];
      HRESP  = HRESP_S[dsel[1:0]];
      HRDATA = HRDATA_S[{dsel[1:0], 5'b0} +: 32];
    end
  end

endmodule

// File: tb/tb_ahblite_interconnect.sv
module tb_ahblite_interconnect;
  import ahblite_interconnect_pkg::*;

  logic         HCLK;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [3:0]   HSEL_S;
  logic [3:0]   HREADYOUT_S;
  logic [3:0]   HRESP_S;
  logic [127:0] HRDATA_S;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;

  // Slave read data: slave 1 behaves as a one-register memory
  localparam logic [31:0] S0_DATA = 32'h0000_5A00;
  localparam logic [31:0] S2_DATA = 32'hCAFE_0002;
  localparam logic [31:0] S3_DATA = 32'hBEEF_0003;
  logic [31:0] s1_reg;
  assign HRDATA_S = {S3_DATA, S2_DATA, s1_reg, S0_DATA};

  localparam logic [31:0] A_UNM = 32'h5000_0000;
  localparam logic [1:0]  T_I   = HTRANS_IDLE;
  localparam logic [1:0]  T_B   = HTRANS_BUSY;
  localparam logic [1:0]  T_N   = HTRANS_NONSEQ;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: {HSEL_S, HREADY, HRESP, HRDATA}
  logic [37:0] sb[$];
  logic [37:0] got, exp_v;

  ahblite_interconnect dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_S      (HSEL_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle just after the rising edge, return at the falling edge
  task automatic step(input logic [31:0] a, input logic [1:0] t,
                      input logic [3:0] rdy, input logic [3:0] rsp,
                      input logic rstn);
    @(posedge HCLK);
    #1;
    HADDR = a; HTRANS = t; HREADYOUT_S = rdy; HRESP_S = rsp; HRESETn = rstn;
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sb.push_back({4'b0000, 1'b1, 1'b0, 32'h0});
      step(32'h0, T_I, 4'hF, 4'h0, (k == 2));
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] ad [4] = '{32'h4000_1004, 32'h0, 32'h4000_1004, 32'h0};
    logic [1:0]  tr [4] = '{T_N, T_I, T_N, T_I};
    logic [37:0] ex [4] = '{{4'b0010, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0010, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0000_00A5}};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ex[k]);
      step(ad[k], tr[k], 4'hF, 4'h0, 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL write_read[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
      if (k == 1) s1_reg = 32'h0000_00A5;  // write data phase completes
    end
  endtask

  task automatic test_unmapped();
    logic [1:0]  tr [4] = '{T_N, T_I, T_I, T_I};
    logic [37:0] ex [4] = '{{4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b0, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ex[k]);
      step((k == 0) ? A_UNM : 32'h0, tr[k], 4'hF, 4'h0, 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL unmapped[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] ad [6] = '{32'h4000_2000, 32'h4000_3000, A_UNM,
                            32'h4000_3000, 32'h4000_3000, 32'h0};
    logic [1:0]  tr [6] = '{T_N, T_N, T_N, T_N, T_N, T_I};
    logic [3:0]  rd [6] = '{4'hF, 4'b1011, 4'b1011, 4'b1011, 4'hF, 4'hF};
    logic [37:0] ex [6] = '{{4'b0100, 1'b1, 1'b0, 32'h0},
                            {4'b1000, 1'b0, 1'b0, S2_DATA},
                            {4'b0000, 1'b0, 1'b0, S2_DATA},
                            {4'b1000, 1'b0, 1'b0, S2_DATA},
                            {4'b1000, 1'b1, 1'b0, S2_DATA},
                            {4'b0000, 1'b1, 1'b0, S3_DATA}};
    for (int k = 0; k < 6; k++) begin
      sb.push_back(ex[k]);
      step(ad[k], tr[k], rd[k], 4'h0, 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL wait_states[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [5] = '{A_UNM, A_UNM, 32'h4000_0000, 32'h4000_1000, 32'h0};
    logic [1:0]  tr [5] = '{T_I, T_B, T_N, T_N, T_I};
    logic [37:0] ex [5] = '{{4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0001, 1'b1, 1'b0, 32'h0},
                            {4'b0010, 1'b1, 1'b0, S0_DATA},
                            {4'b0000, 1'b1, 1'b0, 32'h0000_00A5}};
    for (int k = 0; k < 5; k++) begin
      sb.push_back(ex[k]);
      step(ad[k], tr[k], 4'hF, 4'h0, 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_err_back_to_back();
    logic [31:0] ad [6] = '{A_UNM, 32'h5000_0004, 32'h5000_0004, 32'h0, 32'h0, 32'h0};
    logic [1:0]  tr [6] = '{T_N, T_N, T_N, T_I, T_I, T_I};
    logic [37:0] ex [6] = '{{4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b0, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b1, 32'h0},
                            {4'b0000, 1'b0, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0}};
    for (int k = 0; k < 6; k++) begin
      sb.push_back(ex[k]);
      step(ad[k], tr[k], 4'hF, 4'h0, 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL err_back_to_back[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_slave_error();
    logic [31:0] ad [4] = '{32'h4000_3000, 32'h0, 32'h0, 32'h0};
    logic [1:0]  tr [4] = '{T_N, T_I, T_I, T_I};
    logic [3:0]  rd [4] = '{4'hF, 4'b0111, 4'hF, 4'hF};
    logic [3:0]  rs [4] = '{4'h0, 4'b1000, 4'b1000, 4'h0};
    logic [37:0] ex [4] = '{{4'b1000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b0, 1'b1, S3_DATA},
                            {4'b0000, 1'b1, 1'b1, S3_DATA},
                            {4'b0000, 1'b1, 1'b0, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ex[k]);
      step(ad[k], tr[k], rd[k], rs[k], 1'b1);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL slave_error[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_err();
    logic [1:0]  tr [4] = '{T_N, T_I, T_I, T_I};
    logic        rn [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [37:0] ex [4] = '{{4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b0, 1'b1, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ex[k]);
      step((k == 0) ? A_UNM : 32'h0, tr[k], 4'hF, 4'h0, rn[k]);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_err[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0]  tr [4] = '{T_N, T_I, T_I, T_I};
    logic [3:0]  rd [4] = '{4'hF, 4'b1011, 4'b1011, 4'b1011};
    logic        rn [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [37:0] ex [4] = '{{4'b0100, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b0, 1'b0, S2_DATA},
                            {4'b0000, 1'b1, 1'b0, 32'h0},
                            {4'b0000, 1'b1, 1'b0, 32'h0}};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ex[k]);
      step((k == 0) ? 32'h4000_2000 : 32'h0, tr[k], rd[k], 4'h0, rn[k]);
      got = {HSEL_S, HREADY, HRESP, HRDATA};
      exp_v = sb.pop_front();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_wait[%0d] got {hsel,rdy,resp,rdata}=%h expected %h", k, got, exp_v);
      end
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h0;
    HTRANS      = HTRANS_IDLE;
    HREADYOUT_S = 4'hF;
    HRESP_S     = 4'h0;
    s1_reg      = 32'h0;

    test_reset();
    test_write_read();
    test_unmapped();
    test_wait_states();
    test_back_to_back();
    test_err_back_to_back();
    test_slave_error();
    test_reset_mid_err();
    test_reset_mid_wait();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
